or4x2_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one WIDTH-bit output lane among four requesters (ports 0..3).
- The any-request term is the 4-input OR of REQ.
- The grant is registered and held (locked) while the owner keeps its request asserted.
- The owner's data is steered to O.
- Sits in front of a shared 2-bit bus such as a J3-style output header.

---
 rtl/or4x2_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_or4x2_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/or4x2_rr_arbiter.sv
// Four-port round-robin arbiter with locked grant, steering the owner's lane to O.
// Optional macro ARB_TIMEOUT_EN adds a MAX_HOLD preemption counter.
module or4x2_rr_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       REQ,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [3:0]       GNT,
    output logic [1:0]       GNT_IDX,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] O
);

    typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_gnt_idx, w_gnt_idx_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic             w_new_grant;
    logic             w_timeout;
    logic [3:0]       w_others;
    logic [2:0]       w_pick_idle, w_pick_own;
    logic [WIDTH-1:0] w_lane;

    // Returns {found, index} of the first set bit searching base, base+1, ... mod 4.
    function automatic logic [2:0] f_search(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        f_search = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (req[idx]) f_search = {1'b1, idx};
        end
    endfunction

    assign w_others    = REQ & ~r_gnt;
    assign w_pick_idle = f_search(REQ, r_ptr);
    assign w_pick_own  = f_search(w_others, r_gnt_idx + 2'd1);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] r_hold_cnt;

    assign w_timeout = (r_state == ST_OWN) && (r_hold_cnt >= HOLD_LAST) && (|w_others);

    always_ff @(posedge CLK) begin
        if (RESET)
            r_hold_cnt <= 8'd0;
        else if (w_new_grant)
            r_hold_cnt <= 8'd0;
        else if (r_state == ST_OWN && r_hold_cnt < HOLD_LAST)
            r_hold_cnt <= r_hold_cnt + 8'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_ptr_nxt     = r_ptr;
        w_new_grant   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[2]) begin
                    w_state_nxt   = ST_OWN;
                    w_gnt_nxt     = 4'b0001 << w_pick_idle[1:0];
                    w_gnt_idx_nxt = w_pick_idle[1:0];
                    w_new_grant   = 1'b1;
                end
            end
            ST_OWN: begin
                // Release and timeout both rotate priority past the owner and hand over with no bubble.
                if (!REQ[r_gnt_idx] || w_timeout) begin
                    w_ptr_nxt = r_gnt_idx + 2'd1;
                    if (w_pick_own[2]) begin
                        w_gnt_nxt     = 4'b0001 << w_pick_own[1:0];
                        w_gnt_idx_nxt = w_pick_own[1:0];
                        w_new_grant   = 1'b1;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_gnt_nxt     = 4'b0000;
                        w_gnt_idx_nxt = 2'd0;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_gnt_nxt     = 4'b0000;
                w_gnt_idx_nxt = 2'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 4'b0000;
            r_gnt_idx <= 2'd0;
            r_ptr     <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    always_comb begin
        case (r_gnt_idx)
            2'd0:    w_lane = I0;
            2'd1:    w_lane = I1;
            2'd2:    w_lane = I2;
            default: w_lane = I3;
        endcase
    end

    assign GNT     = r_gnt;
    assign GNT_IDX = r_gnt_idx;
    assign BUSY    = (r_state == ST_OWN);
    assign VALID   = ~RESET & BUSY & REQ[r_gnt_idx];
    assign O       = VALID ? w_lane : '0;

endmodule

// File: tb/tb_or4x2_rr_arbiter.sv
// Self-checking bench for or4x2_rr_arbiter: directed scenarios plus random traffic
// against an owner/pointer reference model.
module tb_or4x2_rr_arbiter;
    localparam int WIDTH    = 2;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] din [4];
    logic [3:0]       GNT;
    logic [1:0]       GNT_IDX;
    logic             BUSY, VALID;
    logic [WIDTH-1:0] O;

    int total = 0;
    int bad   = 0;
    int m_owner, m_ptr, m_cnt;

    always #5 clk = ~clk;

    or4x2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK(clk), .RESET(rst), .REQ(req),
        .I0(din[0]), .I1(din[1]), .I2(din[2]), .I3(din[3]),
        .GNT(GNT), .GNT_IDX(GNT_IDX), .BUSY(BUSY), .VALID(VALID), .O(O)
    );

    function automatic int first_from(input logic [3:0] r, input int base);
        for (int k = 0; k < 4; k++)
            if (r[(base + k) % 4]) return (base + k) % 4;
        return -1;
    endfunction

    task automatic model_edge();
        int g, nxt;
        logic [3:0] others;
        logic tmo;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            nxt = first_from(req, m_ptr);
            if (nxt >= 0) begin m_owner = nxt; m_cnt = 0; end
        end else begin
            g = m_owner;
            others = req;
            others[g] = 1'b0;
            tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo = (m_cnt >= MAX_HOLD - 1) && (others != 4'b0);
`endif
            if (!req[g] || tmo) begin
                m_ptr   = (g + 1) % 4;
                m_owner = first_from(others, m_ptr);
                m_cnt   = 0;
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [9:0] exp_vec();
        logic [3:0] g;
        logic [1:0] idx;
        logic b, v;
        logic [WIDTH-1:0] o;
        g = 4'b0; idx = 2'd0; b = 1'b0; v = 1'b0; o = '0;
        if (m_owner >= 0) begin
            g   = 4'(1 << m_owner);
            idx = 2'(m_owner);
            b   = 1'b1;
            if (!rst && req[m_owner]) v = 1'b1;
        end
        if (v) o = din[m_owner];
        return {g, idx, b, v, o};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {GNT, GNT_IDX, BUSY, VALID, O};
    endfunction

    task automatic drive(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        for (int i = 0; i < 4; i++) din[i] = WIDTH'($urandom);
        #2;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(4'b1111, 1'b1); advance();
        drive(4'b1111, 1'b1);
        total++;
        if (VALID !== 1'b0 || O !== 2'b00) begin
            bad++; $display("FAIL reset_comb VALID=%b O=%b want 0/00", VALID, O);
        end
        advance();
        total++;
        if (GNT !== 4'b0 || BUSY !== 1'b0 || O !== 2'b00 || GNT_IDX !== 2'd0) begin
            bad++; $display("FAIL reset_state GNT=%b BUSY=%b O=%b IDX=%0d", GNT, BUSY, O, GNT_IDX);
        end
        drive(4'b1111, 1'b0); advance();
        total++;
        if (GNT !== 4'b0001 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_first_grant got=%b want GNT=0001 vec=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        drive(4'b0000, 1'b1); advance();
        drive(4'b0100, 1'b0);
        din[2] = 2'b10;
        advance();
        total++;
        if (GNT !== 4'b0100 || GNT_IDX !== 2'd2 || VALID !== 1'b1 || O !== 2'b10) begin
            bad++; $display("FAIL single_grant GNT=%b IDX=%0d VALID=%b O=%b want 0100/2/1/10", GNT, GNT_IDX, VALID, O);
        end
        drive(4'b0000, 1'b0);
        total++;
        if (GNT !== 4'b0100 || VALID !== 1'b0 || O !== 2'b00) begin
            bad++; $display("FAIL single_release_cycle GNT=%b VALID=%b O=%b want 0100/0/00", GNT, VALID, O);
        end
        advance();
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
            bad++; $display("FAIL single_idle GNT=%b BUSY=%b want 0000/0", GNT, BUSY);
        end
    endtask

    task automatic test_rotation();
        drive(4'b0000, 1'b1); advance();
        drive(4'b1111, 1'b0); advance();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                drive(4'b1111, 1'b0); advance();
                total++;
                if (GNT !== 4'(1 << k) || obs_vec() !== exp_vec()) begin
                    bad++; $display("FAIL rotation_hold owner=%0d got=%b want=%b", k, obs_vec(), exp_vec());
                end
            end
            drive(4'b1111 & ~4'(1 << k), 1'b0); advance();
            total++;
            if (GNT !== 4'(1 << ((k + 1) % 4)) || BUSY !== 1'b1) begin
                bad++; $display("FAIL rotation_handover from=%0d GNT=%b BUSY=%b want %b/1", k, GNT, BUSY, 4'(1 << ((k + 1) % 4)));
            end
        end
    endtask

    task automatic test_lock();
        drive(4'b0000, 1'b1); advance();
        drive(4'b0010, 1'b0); advance();
        for (int c = 0; c < 20; c++) begin
            drive(4'b1010, 1'b0); advance();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL lock_model cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
`ifndef ARB_TIMEOUT_EN
            total++;
            if (GNT !== 4'b0010) begin
                bad++; $display("FAIL lock_hold cyc=%0d GNT=%b want 0010", c, GNT);
            end
`endif
        end
        drive(4'b1000, 1'b0); advance();
        total++;
        if (GNT !== 4'b1000) begin
            bad++; $display("FAIL lock_release GNT=%b want 1000", GNT);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        drive(4'b0000, 1'b1); advance();
        drive(4'b0001, 1'b0); advance();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (GNT !== 4'b0001) begin
                bad++; $display("FAIL timeout_hold cyc=%0d GNT=%b want 0001", c, GNT);
            end
            drive(4'b0101, 1'b0); advance();
        end
        total++;
        if (GNT !== 4'b0100 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL timeout_preempt GNT=%b want 0100", GNT);
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive(4'b0000, 1'b1); advance();
        drive(4'b1000, 1'b0); advance();
        total++;
        if (GNT !== 4'b1000) begin
            bad++; $display("FAIL midreset_setup GNT=%b want 1000", GNT);
        end
        drive(4'b1000, 1'b1);
        total++;
        if (VALID !== 1'b0 || O !== 2'b00) begin
            bad++; $display("FAIL midreset_comb VALID=%b O=%b want 0/00", VALID, O);
        end
        advance();
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
            bad++; $display("FAIL midreset_clear GNT=%b BUSY=%b want 0000/0", GNT, BUSY);
        end
        drive(4'b1001, 1'b0); advance();
        total++;
        if (GNT !== 4'b0001 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL midreset_regrant GNT=%b want 0001", GNT);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = 4'b0;
        drive(4'b0000, 1'b1); advance();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            drive(r, ($urandom_range(0, 39) == 0));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_comb cyc=%0d req=%b got=%b want=%b", c, r, obs_vec(), exp_vec());
            end
            advance();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_edge cyc=%0d req=%b got=%b want=%b", c, r, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        m_owner = -1; m_ptr = 0; m_cnt = 0;
        test_reset();
        test_single();
        test_rotation();
        test_lock();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
